// File: rtl/piso_pkg.sv
// Shared types and helpers for the parallel-in/serial-out streamer.
package piso_pkg;

  typedef enum logic {IDLE, SHIFT} piso_state_e;

  localparam int MAX_W = 64;

  // Reverses the low w bits of d. Callers zero-extend narrower words to MAX_W.
  function automatic logic [MAX_W-1:0] bit_reverse(input logic [MAX_W-1:0] d,
                                                   input int unsigned w);
    logic [MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_W; i++) r[i] = d[MAX_W-1-i];
    return r >> (MAX_W - w);
  endfunction

endpackage

// File: rtl/piso_stream.sv
// Serializer: takes a WIDTH-bit word over valid/ready and emits it one bit per
// cycle, MSB or LSB first per word, with back-pressure, last marker and flush.
module piso_stream
  import piso_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_lsb_first,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_data,
  output logic             out_last,
  input  logic             flush,
  output logic             busy
);

  piso_state_e      state, state_nxt;
  logic [WIDTH-1:0] shift_reg;
  logic [CNT_W-1:0] bit_cnt;
  logic [WIDTH-1:0] load_word;
  logic             accept, xfer;

  assign out_valid = (state == SHIFT);
  assign busy      = out_valid;
  assign out_data  = shift_reg[WIDTH-1];
  assign out_last  = out_valid && (bit_cnt == CNT_W'(WIDTH-1));
  // rst gates in_ready so no producer sees a ready that the flops will ignore.
  assign in_ready  = !rst && !flush && ((state == IDLE) || (out_ready && out_last));
  assign accept    = in_valid && in_ready;
  assign xfer      = out_valid && out_ready;

  // Storing LSB-first words pre-reversed keeps the output tap fixed at the MSB.
  assign load_word = in_lsb_first ? WIDTH'(bit_reverse(MAX_W'(in_data), WIDTH)) : in_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (flush)                 state_nxt = IDLE;
    else if (accept)           state_nxt = SHIFT;
    else if (xfer && out_last) state_nxt = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
    end else if (flush) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
    end else if (accept) begin
      shift_reg <= load_word;
      bit_cnt   <= '0;
    end else if (xfer) begin
      shift_reg <= shift_reg << 1;
      bit_cnt   <= out_last ? '0 : bit_cnt + CNT_W'(1);
    end
  end

  a_stall_hold: assert property (@(posedge clk) disable iff (rst)
    out_valid && !out_ready && !flush |=> $stable(out_data) && out_valid);

  a_last_valid: assert property (@(posedge clk) disable iff (rst)
    out_last |-> out_valid);

  // Together these pin exactly WIDTH transfers from each accept to its last bit.
  a_cnt_start: assert property (@(posedge clk) disable iff (rst)
    accept && !flush |=> bit_cnt == '0);

  a_cnt_step: assert property (@(posedge clk) disable iff (rst)
    xfer && !out_last && !flush |=> bit_cnt == CNT_W'($past(bit_cnt) + 1'b1));

endmodule

// File: doc/piso_stream.md
Name: piso_stream

Overview:
- Parametrised parallel-in/serial-out serializer with valid/ready handshakes on both sides.
- Accepts a WIDTH-bit word, emits it one bit per cycle, MSB-first or LSB-first selected per word.
- Supports downstream back-pressure, zero-bubble back-to-back words, a per-word last-bit marker and a synchronous flush.
- Sits between a parallel producer (register block, FIFO) and a serial line driver.

Parameters:
WIDTH, 8, word width in bits; legal range 2..64.
CNT_W, $clog2(WIDTH), bit-counter width; derived, not overridden.

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  asynchronous active-high reset
in_valid  input  1  producer has a word on in_data
in_ready  output  1  block accepts a word this cycle (combinational from state and out_ready)
in_data  input  WIDTH  parallel word, sampled on accept
in_lsb_first  input  1  bit order for this word: 0 = MSB first, 1 = LSB first; sampled on accept
out_valid  output  1  out_data holds a valid serial bit
out_ready  input  1  consumer takes the bit this cycle
out_data  output  1  current serial bit
out_last  output  1  current bit is the final bit of its word
flush  input  1  synchronous abort of the word in flight
busy  output  1  word in flight (equals out_valid)

Behaviour:
- Reset (rst high, async): state IDLE, shift_reg = 0, bit_cnt = 0, out_valid = out_data = out_last = busy = 0. in_ready is forced 0 while rst is high. in_ready is 1 on the first cycle after release.
- FSM has two states, IDLE and SHIFT. out_valid = (state == SHIFT).
- Accept: in_valid && in_ready at a rising edge.
  - Loads shift_reg with in_data, bit-reversed if in_lsb_first = 1.
  - Sets bit_cnt = 0 and enters SHIFT.
  - The first bit is on out_data on the next cycle (latency 1).
- out_data = shift_reg[WIDTH-1]. out_last = out_valid && (bit_cnt == WIDTH-1).
- Bit transfer: out_valid && out_ready.
  - Not last bit: shift_reg shifts left with 0 fill; bit_cnt increments.
  - Last bit with in_valid = 1: accepts the next word in the same cycle; no idle cycle between words.
  - Last bit with in_valid = 0: returns to IDLE.
- in_ready = !flush && (state == IDLE || (out_ready && out_last)).
- Stall: out_ready = 0 holds out_data, out_last, bit_cnt and shift_reg unchanged. out_valid stays 1 (valid never drops without a transfer, except on flush or reset).
- Flush (sync, highest priority after reset):
  - Next cycle: state IDLE, out_valid = 0, shift_reg and bit_cnt cleared.
  - in_ready = 0 in the flush cycle, so a simultaneous in_valid is not accepted.
  - Flush in IDLE has no effect beyond that.
- Reset mid-word: all outputs clear immediately (asynchronously). The partial word is discarded and never resumed.
- in_data and in_lsb_first are don't-care except in accept cycles.
- Assertions:
  - out_valid && !out_ready |=> $stable(out_data) && out_valid, unless flush.
  - out_last implies out_valid.
  - Exactly WIDTH transfers between consecutive out_last pulses, with no flush in between.

Decomposition:
- Package piso_pkg: typedef enum logic {IDLE, SHIFT} piso_state_e; function bit_reverse, parameterised by width through a parameterised class or a fixed-max helper.
- No sub-module: the counter and shift register are a single always_ff. in_ready and out_last are continuous assigns.

Test Plan:
- WIDTH=8, out_ready=1, in_data=8'hA5, in_lsb_first=0 -> out_data 1,0,1,0,0,1,0,1 on 8 consecutive cycles starting 1 cycle after accept; out_last only on the 8th.
- in_data=8'h01, in_lsb_first=1 -> out_data 1,0,0,0,0,0,0,0; then in_data=8'h80, in_lsb_first=0 -> the same sequence.
- Back-to-back 8'hF0 then 8'h0F, in_valid held high -> 16 contiguous out_valid cycles reading 1111000000001111; in_ready high exactly on the accept cycles (cycle 0 and cycle 8).
- out_ready low for 3 cycles while bit index 3 of 8'hA5 is presented -> out_data holds 0 for 4 cycles; word completes with the correct remaining bits; total 11 cycles.
- flush asserted at bit 4 of 8'hFF with in_valid=1 and in_data=8'h55 -> out_valid 0 next cycle; 8'h55 not accepted until the following cycle; then serialized as 01010101.
- rst pulsed asynchronously mid-cycle at bit 2 -> out_valid, out_data and out_last drop to 0 without waiting for a clock edge; in_ready 1 on the first cycle after release; a new word serializes correctly.
